// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Load/store unit sitting between a requester and a single-ported,
// word-wide DATA_RAM.  One request is taken at a time (req_ready is high only
// while idle).  Loads read the addressed word and return the extracted,
// zero- or sign-extended lane.  Word stores write directly.  Byte and
// halfword stores use read-modify-write.  Misaligned or invalid-size
// requests complete one cycle after acceptance with misalign=1 and never
// touch the RAM.
//
// Ports
//   Clock, Reset          : clock and synchronous active-high reset
//   req_valid / req_ready : request handshake (accept when both high)
//   req_we                : 1 = store, 0 = load
//   req_size              : 00 byte, 01 halfword, 10 word, 11 invalid
//   req_signed            : sign-extend sub-word loads
//   req_addr, req_wdata   : byte address, right-aligned store data
//   resp_valid            : one-cycle completion pulse
//   resp_rdata            : load result (held between load/error completions)
//   misalign              : marks the resp_valid pulse as an error completion
//   ram_addr, ram_datain  : word address and write data to DATA_RAM
//   ram_write, ram_read   : DATA_RAM strobes (never both high)
//   ram_dataout           : DATA_RAM read data (sampled at the end of RD2)
module mem_access_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_datain,
    output logic        ram_write,
    output logic        ram_read,
    input  logic [31:0] ram_dataout
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Alignment rule: halfwords need an even address, words a multiple of 4,
    // size 11 is always rejected.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic v;
        case (size)
            2'b00:   v = 1'b0;
            2'b01:   v = off[0];
            2'b10:   v = (off != 2'b00);
            default: v = 1'b1;
        endcase
        return v;
    endfunction

    // Extract the addressed little-endian lane and extend it to 32 bits.
    function automatic logic [31:0] f_load_extend(input logic [31:0] word, input logic [1:0] size,
                                                  input logic sgn, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane(s) of the old word with the store data.
    function automatic logic [31:0] f_store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                  input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (off)
                    2'b00:   r[7:0]   = wdata[7:0];
                    2'b01:   r[15:8]  = wdata[7:0];
                    2'b10:   r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_misalign;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_datain;
    logic        r_ram_write;
    logic        r_ram_read;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_load_done;
    logic        w_next_ram;

    // All RAM-side outputs are registered from the next state, so they line
    // up with the state they belong to.  On the accept edge the registered
    // request is not yet available, so the live request fields are used.
    assign w_addr      = (r_state == IDLE) ? req_addr : r_addr;
    assign w_wdata     = (r_state == IDLE) ? req_wdata
                                           : f_store_merge(ram_dataout, r_wdata, r_size, r_addr[1:0]);
    assign w_load_done = (r_state == RD2) && !r_we;
    assign w_next_ram  = (w_next_state == RD1) || (w_next_state == RD2) || (w_next_state == WR);

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign misalign   = r_misalign;
    assign ram_addr   = r_ram_addr;
    assign ram_datain = r_ram_datain;
    assign ram_write  = r_ram_write;
    assign ram_read   = r_ram_read;

    // Next-state logic and request acceptance.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (f_misaligned(req_size, req_addr[1:0])) begin
                        w_next_state = ERR;
                    end else if (req_we && (req_size == 2'b10)) begin
                        w_next_state = WR;
                    end else begin
                        // loads and sub-word stores both start with a read
                        w_next_state = RD1;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            RD1: w_next_state = RD2;
            RD2: begin
                if (r_we) begin
                    w_next_state = WR;
                end else begin
                    w_next_state = RESP;
                end
            end
            WR:      w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            ERR:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register, captured request and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_misalign   <= 1'b0;
            r_ram_addr   <= 32'd0;
            r_ram_datain <= 32'd0;
            r_ram_write  <= 1'b0;
            r_ram_read   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            r_ram_read   <= (w_next_state == RD1) || (w_next_state == RD2);
            r_ram_write  <= (w_next_state == WR);
            r_ram_addr   <= w_next_ram ? {w_addr[31:2], 2'b00} : 32'd0;
            r_ram_datain <= (w_next_state == WR) ? w_wdata : 32'd0;
            r_resp_valid <= (w_next_state == RESP) || (w_next_state == ERR);
            r_misalign   <= (w_next_state == ERR);
            // resp_rdata only moves on load or error completion
            if (w_next_state == ERR) begin
                r_resp_rdata <= 32'd0;
            end else if (w_load_done) begin
                r_resp_rdata <= f_load_extend(ram_dataout, r_size, r_signed, r_addr[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, hand-written reset
// and handshake sequences, then random requests against a reference model.
module tb_mem_access_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign;
    logic [31:0] ram_addr;
    logic [31:0] ram_datain;
    logic        ram_write;
    logic        ram_read;
    logic [31:0] ram_dataout = 32'd0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] ref_last = 32'd0;

    mem_access_unit dut (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign(misalign),
        .ram_addr(ram_addr), .ram_datain(ram_datain),
        .ram_write(ram_write), .ram_read(ram_read), .ram_dataout(ram_dataout)
    );

    always #5 Clock = ~Clock;

    // DATA_RAM model: synchronous read and write, 64 words.
    always @(posedge Clock) begin
        if (ram_write) mem[ram_addr[7:2]] <= ram_datain;
        if (ram_read)  ram_dataout <= mem[ram_addr[7:2]];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] addr);
        return (sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0) || (sz == 2'd2 && (addr % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic sg, input logic [31:0] addr);
        logic [4:0]  sh;
        logic [31:0] v;
        sh = {addr[1:0], 3'b000};
        if (sz == 2'd2) return word;
        v = word >> sh;
        if (sz == 2'd0) begin
            v = v & 32'h000000FF;
            if (sg && v >= 32'h00000080) v = v | 32'hFFFFFF00;
        end else begin
            v = v & 32'h0000FFFF;
            if (sg && v >= 32'h00008000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [31:0] addr);
        logic [4:0]  sh;
        logic [31:0] mask;
        if (sz == 2'd2) return wd;
        sh   = {addr[1:0], 3'b000};
        mask = ((sz == 2'd0) ? 32'h000000FF : 32'h0000FFFF) << sh;
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    // Issue one request from IDLE, watch every cycle until completion and
    // compare against the supplied expectations.
    task automatic apply(input string nm, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] e_rdata, input logic e_mis, input int e_lat,
                         input logic [31:0] e_datain);
        logic [31:0] g_rdata;
        logic [31:0] g_datain;
        logic        g_mis;
        int lat, nwr, nrd, nbad, e_wr, e_rd;
        g_rdata = 32'd0; g_datain = 32'd0; g_mis = 1'b0;
        lat = 0; nwr = 0; nrd = 0; nbad = 0;
        @(negedge Clock);
        req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        if (req_ready !== 1'b1) nbad++;
        @(posedge Clock); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) begin @(posedge Clock); #1; end
            if (ram_read && ram_write) nbad++;
            if (ram_addr !== ((ram_read || ram_write) ? {addr[31:2], 2'b00} : 32'd0)) nbad++;
            if (!ram_write && ram_datain !== 32'd0) nbad++;
            if (ram_read) nrd++;
            if (ram_write) begin nwr++; g_datain = ram_datain; end
            if (resp_valid) begin
                lat = n; g_rdata = resp_rdata; g_mis = misalign;
                break;
            end
        end
        @(posedge Clock); #1;
        if (resp_valid !== 1'b0 || ram_read || ram_write) nbad++;
        e_wr = (we && !e_mis) ? 1 : 0;
        e_rd = (!e_mis && !(we && sz == 2'd2)) ? 2 : 0;
        check({nm, " rdata"}, g_rdata, e_rdata);
        check({nm, " misalign"}, {31'd0, g_mis}, {31'd0, e_mis});
        check({nm, " latency"}, 32'(lat), 32'(e_lat));
        check({nm, " writes"}, 32'(nwr), 32'(e_wr));
        check({nm, " reads"}, 32'(nrd), 32'(e_rd));
        check({nm, " protocol"}, 32'(nbad), 32'd0);
        if (e_wr == 1) begin
            check({nm, " datain"}, g_datain, e_datain);
            ref_mem[addr[7:2]] = e_datain;
            check({nm, " ramword"}, mem[addr[7:2]], ref_mem[addr[7:2]]);
        end
        if (!we || e_mis) ref_last = e_rdata;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        logic [31:0] datain;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [31:0] r;
        logic        we, sg, mis;
        logic [1:0]  sz;
        logic [31:0] addr, wd, e_rd, e_din;
        int          e_lat, n_acc, n_resp;

        for (int i = 0; i < 64; i++) begin
            r = $urandom;
            mem[i] <= r;
            ref_mem[i] = r;
        end
        mem[2] <= 32'h11223344; ref_mem[2] = 32'h11223344;
        mem[3] <= 32'h8000FF80; ref_mem[3] = 32'h8000FF80;

        //             we    sz     sg    addr   wdata          rdata          mis  lat datain
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h4, 32'h0000FFFF, 32'h00000000, 1'b0, 2, 32'h0000FFFF};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        32'h0000FFFF, 1'b0, 3, 32'h0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AB, 32'h0000FFFF, 1'b0, 4, 32'h1122AB44};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'hC, 32'h0,        32'hFFFFFF80, 1'b0, 3, 32'h0};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'hE, 32'h0,        32'h00008000, 1'b0, 3, 32'h0};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'hE, 32'h0,        32'hFFFF8000, 1'b0, 3, 32'h0};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h5, 32'h0,        32'h00000000, 1'b1, 1, 32'h0};
        tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h6, 32'h12345678, 32'h00000000, 1'b1, 1, 32'h0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,        32'h1122AB44, 1'b0, 3, 32'h0};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,       32'h00000000, 1'b1, 1, 32'h0};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 32'hB, 32'h0,        32'h00000011, 1'b0, 3, 32'h0};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 32'hE, 32'h1234ABCD, 32'h00000011, 1'b0, 4, 32'hABCDFF80};
        tbl[12] = '{1'b0, 2'd2, 1'b1, 32'hC, 32'h0,        32'hABCDFF80, 1'b0, 3, 32'h0};
        tbl[13] = '{1'b1, 2'd0, 1'b0, 32'hF, 32'hFFFFFF01, 32'hABCDFF80, 1'b0, 4, 32'h01CDFF80};
        tbl[14] = '{1'b0, 2'd0, 1'b1, 32'hF, 32'h0,        32'h00000001, 1'b0, 3, 32'h0};

        // Reset state
        repeat (3) @(posedge Clock);
        #1;
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset misalign", {31'd0, misalign}, 32'd0);
        check("reset ram_strobes", {30'd0, ram_read, ram_write}, 32'd0);
        check("reset ram_addr", ram_addr, 32'd0);
        check("reset ram_datain", ram_datain, 32'd0);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge Clock);
        Reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr,
                  tbl[i].wd, tbl[i].rdata, tbl[i].mis, tbl[i].lat, tbl[i].datain);
        end

        // Reset during RD2 of a byte store aborts it
        @(negedge Clock);
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h8; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge Clock); #1;
        req_valid = 1'b0;
        @(posedge Clock); #1;
        check("abort in_rd2", {31'd0, ram_read}, 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock); #1;
        check("abort post_reset_strobes", {29'd0, ram_write, resp_valid, ram_read}, 32'd0);
        check("abort post_reset_rdata", resp_rdata, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        ref_last = 32'd0;
        n_resp = 0;
        repeat (4) begin
            @(posedge Clock); #1;
            if (ram_write || resp_valid) n_resp++;
        end
        check("abort quiet", 32'(n_resp), 32'd0);
        check("abort req_ready", {31'd0, req_ready}, 32'd1);
        check("abort ramword", mem[2], ref_mem[2]);
        apply("after_abort", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, ref_mem[2], 1'b0, 3, 32'h0);

        // req_valid held through a load: exactly one accept
        @(negedge Clock);
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h4; req_valid = 1'b1;
        n_acc = 0; n_resp = 0;
        for (int i = 0; i < 3; i++) begin
            if (req_ready && req_valid) n_acc++;
            @(posedge Clock); #1;
            if (resp_valid) n_resp++;
            @(negedge Clock);
        end
        if (req_ready) n_acc++;
        req_valid = 1'b0;
        check("hold accepts", 32'(n_acc), 32'd1);
        check("hold resp", 32'(n_resp), 32'd1);
        check("hold rdata", resp_rdata, ref_mem[1]);
        @(posedge Clock); #1;
        check("hold back_idle", {30'd0, req_ready, resp_valid}, 32'd2);

        // req_valid held with a misaligned request: accepts every other cycle
        @(negedge Clock);
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h6; req_valid = 1'b1;
        n_acc = 0; n_resp = 0;
        for (int i = 0; i < 4; i++) begin
            if (req_ready && req_valid) n_acc++;
            @(posedge Clock); #1;
            if (resp_valid && misalign) n_resp++;
            @(negedge Clock);
        end
        req_valid = 1'b0;
        check("errhold accepts", 32'(n_acc), 32'd2);
        check("errhold resp", 32'(n_resp), 32'd2);
        @(posedge Clock); #1;
        ref_last = 32'd0;

        // Random requests against the reference model
        for (int t = 0; t < 250; t++) begin
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            sg   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 255));
            wd   = $urandom;
            mis  = ref_mis(sz, addr);
            e_din = 32'd0;
            if (mis) begin
                e_rd = 32'd0; e_lat = 1;
            end else if (!we) begin
                e_rd = ref_load(ref_mem[addr[7:2]], sz, sg, addr); e_lat = 3;
            end else begin
                e_rd  = ref_last;
                e_din = ref_merge(ref_mem[addr[7:2]], wd, sz, addr);
                e_lat = (sz == 2'd2) ? 2 : 4;
            end
            repeat ($urandom_range(0, 2)) @(posedge Clock);
            apply($sformatf("rand%0d", t), we, sz, sg, addr, wd, e_rd, mis, e_lat, e_din);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
